// File: rtl/halton_seq_gen.sv
// Parametrised Halton (radical-inverse) sequence generator.
// A base-BASE digit counter is digit-reversed and scaled to an OUTWIDTH-bit
// sample, giving one low-discrepancy sample per enabled cycle.
module halton_seq_gen #(
  parameter int unsigned BASE     = 5,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned OUTWIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              clr,
  input  logic                              ld,
  input  logic [DIGITS*$clog2(BASE)-1:0]    seed,
  output logic [OUTWIDTH-1:0]               out,
  output logic                              valid,
  output logic                              wrap
);

  localparam int unsigned DW  = $clog2(BASE);
  localparam int unsigned P   = BASE ** DIGITS;
  localparam int unsigned PW  = $clog2(P);
  localparam int unsigned PRW = PW + OUTWIDTH;
  localparam logic [DW-1:0] DMAX = DW'(BASE - 1);

  logic [DIGITS-1:0][DW-1:0] cnt;
  logic [DIGITS-1:0][DW-1:0] cnt_inc;
  logic [DIGITS-1:0][DW-1:0] seed_clamped;
  logic                      at_last;
  logic [PW-1:0]             rev;
  logic [PRW-1:0]            prod;
  logic [OUTWIDTH-1:0]       sample;

  // Ripple base-BASE increment; wraps from P-1 to 0 naturally
  always_comb begin
    logic carry;
    carry   = 1'b1;
    cnt_inc = cnt;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (cnt[i] == DMAX) begin
          cnt_inc[i] = '0;
        end else begin
          cnt_inc[i] = cnt[i] + DW'(1);
          carry      = 1'b0;
        end
      end
    end
  end

  // Index P-1 is the state with every digit at BASE-1
  always_comb begin
    at_last = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (cnt[i] != DMAX) at_last = 1'b0;
    end
  end

  // Digit reversal by Horner evaluation, LSD of cnt becomes MSD of rev
  always_comb begin
    rev = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      rev = PW'(rev * PW'(BASE)) + PW'(cnt[i]);
    end
  end

  // Scale rev/P onto the output range; rev < P keeps the quotient in range
  always_comb begin
    prod   = PRW'(rev) << OUTWIDTH;
    sample = OUTWIDTH'(prod / PRW'(P));
  end

  // Out-of-range seed digits saturate to the largest legal digit
  always_comb begin
    seed_clamped = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (32'(seed[i*DW +: DW]) >= BASE) seed_clamped[i] = DMAX;
      else                               seed_clamped[i] = seed[i*DW +: DW];
    end
  end

  // Index counter with clr > ld > en priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= seed_clamped;
    end else if (en) begin
      cnt <= cnt_inc;
    end
  end

  // Registered sample and flags; a load keeps the last sample but marks it stale
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (clr) begin
      out   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (ld) begin
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (en) begin
      out   <= sample;
      valid <= 1'b1;
      wrap  <= at_last;
    end
  end

endmodule
